pipe_flow_ctrl: RTL and testbench
=================================

PIPE_FLOW_CTRL -- requirements
Module: pipe_flow_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 6, number of external interrupt lines (1..32).
REQ-002 SHALL have parameter MUL_LAT, default 5, multiply busy cycles (>=2).
REQ-003 SHALL have parameter DIV_LAT, default 10, divide busy cycles (>=2).
REQ-004 SHALL have parameter CNT_W, default 5, busy counter width; must hold max(MUL_LAT,DIV_LAT)-1.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 reset  input  1  asynchronous active-low reset.
REQ-008 irq  input  NUM_IRQ  external interrupt lines.
REQ-009 irq_mask  input  NUM_IRQ  per-line enable from CP0, 1 = enabled.
REQ-010 exl  input  1  CP0 exception level; 1 blocks acceptance.
REQ-011 uncertain_jump  input  1  ID holds a branch or register jump.
REQ-012 load_use  input  1  load-use hazard detected in ID.
REQ-013 md_start  input  1  ID holds mult/multu/div/divu.
REQ-014 md_is_div  input  1  qualifies md_start: 1 = divide.
REQ-015 md_access  input  1  ID holds mfhi/mflo/mthi/mtlo.
REQ-016 pipeline_stall  output  1  hold IF/ID, bubble EX.
REQ-017 pc_write  output  1  PC update enable.
REQ-018 id_flush  output  1  insert bubble into ID/EX.
REQ-019 if_flush  output  1  flush IF/ID on interrupt entry.
REQ-020 int_req  output  1  one-cycle interrupt entry pulse (EXL set, NPC to handler).
REQ-021 int_cause  output  $clog2(NUM_IRQ) (min 1)  index of accepted line.
REQ-022 md_busy  output  1  multiply/divide in flight.

Function
REQ-023 SHALL implement states IDLE, MD_BUSY, INT_TAKE.
REQ-024 pipeline_stall SHALL be load_use | (md_busy & (md_start | md_access)), combinational.
REQ-025 pc_write SHALL equal !pipeline_stall; id_flush SHALL equal pipeline_stall.
REQ-026 In IDLE with md_start & !pipeline_stall, SHALL load counter with (md_is_div ? DIV_LAT : MUL_LAT)-1 and enter MD_BUSY next cycle.
REQ-027 In MD_BUSY the counter SHALL decrement each cycle; at count 0 SHALL return to IDLE next cycle, giving exactly MUL_LAT/DIV_LAT cycles with md_busy=1.
REQ-028 md_busy SHALL be 1 iff state is MD_BUSY.
REQ-029 Eligible vector SHALL be pending & irq_mask; lowest set index SHALL win.
REQ-030 Acceptance SHALL occur in IDLE when eligible!=0, !exl, !uncertain_jump, !load_use, !md_start.
REQ-031 md_start and eligible interrupt in the same IDLE cycle: md_start SHALL win; interrupt remains eligible for a later cycle.
REQ-032 Acceptance in cycle t SHALL give state INT_TAKE, int_req=1, if_flush=1, int_cause=winning index in cycle t+1, for exactly one cycle, then IDLE.
REQ-033 int_cause SHALL hold its value until the next acceptance.
REQ-034 No acceptance SHALL occur in MD_BUSY or INT_TAKE.

Reset
REQ-035 On reset low, SHALL go to IDLE and set counter=0, int_cause=0, pending=0, int_req=0, if_flush=0, md_busy=0, independent of clk.
REQ-036 Reset asserted mid-MD_BUSY or in INT_TAKE SHALL abort the operation without any int_req pulse.

Configuration
REQ-037 Macro PFC_IRQ_EDGE_EN defined: pending SHALL be sticky bits set on 0->1 edge of irq, cleared for the accepted index when int_req fires; set and clear on the same bit in one cycle SHALL leave it set.
REQ-038 Macro undefined: pending SHALL equal irq (level-sensitive, no storage).

Structure
REQ-039 State enum and default latency constants SHALL reside in the shared package pipeline_pkg.
REQ-040 Priority encoder SHALL be sub-module pfc_prio_enc (NUM_IRQ-parameterised, combinational).

Verification
REQ-041 Reset low mid-divide (counter 6) -> all outputs 0 immediately; md_busy=0 after release.
REQ-042 md_start, md_is_div=1, DIV_LAT=10 -> md_busy high exactly 10 cycles; md_access at busy cycle 3 -> pipeline_stall=1, pc_write=0, id_flush=1 until IDLE.
REQ-043 irq=6'b010100, mask=all ones, exl=0 -> int_req one cycle later, int_cause=2, if_flush=1 for one cycle.
REQ-044 irq asserted with uncertain_jump=1 for 2 cycles -> no int_req until uncertain_jump drops, then pulse next cycle.
REQ-045 irq asserted while exl=1 -> no int_req; exl drops -> pulse one cycle later.
REQ-046 With PFC_IRQ_EDGE_EN: 1-cycle irq[4] pulse during MUL busy -> int_req, int_cause=4 one cycle after IDLE resumes; without macro -> no int_req.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared types and constants for the pipeline flow controller.
//   pfc_state_t   : controller FSM states (IDLE, MD_BUSY, INT_TAKE)
//   PFC_*_DEF     : default parameter values (interrupt count, mul/div latency,
//                   busy counter width)
//   pfc_idx_w()   : width of an index into an N-entry vector (minimum 1 bit)
// ---------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MD_BUSY  = 2'd1,
        INT_TAKE = 2'd2
    } pfc_state_t;

    localparam int PFC_NUM_IRQ_DEF = 6;
    localparam int PFC_MUL_LAT_DEF = 5;
    localparam int PFC_DIV_LAT_DEF = 10;
    localparam int PFC_CNT_W_DEF   = 5;

    // A single-entry vector still needs a 1-bit index port.
    function automatic int pfc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pfc_prio_enc.sv
// ---------------------------------------------------------------------------
// pfc_prio_enc
// Combinational lowest-index-wins priority encoder.
// Parameters:
//   NUM_IRQ : number of request lines (1..32)
// Ports:
//   req  in  [NUM_IRQ-1:0]        request vector
//   any  out                      at least one request set
//   idx  out [pfc_idx_w(NUM_IRQ)] index of the lowest set request (0 if none)
// ---------------------------------------------------------------------------
module pfc_prio_enc
    import pipeline_pkg::*;
#(
    parameter int NUM_IRQ = PFC_NUM_IRQ_DEF
) (
    input  logic [NUM_IRQ-1:0]            req,
    output logic                          any,
    output logic [pfc_idx_w(NUM_IRQ)-1:0] idx
);

    localparam int IDX_W = pfc_idx_w(NUM_IRQ);

    // below[i] is set when some request with index < i is active; the winner
    // is the only set request whose below bit is clear.
    logic [NUM_IRQ:0]   below;
    logic [NUM_IRQ-1:0] onehot;

    assign below[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_chain
            assign onehot[gi]    = req[gi] & ~below[gi];
            assign below[gi + 1] = below[gi] | req[gi];
        end
    endgenerate

    assign any = below[NUM_IRQ];

    // onehot has at most one bit set, so OR-ing the indices is exact.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_flow_ctrl
// Pipeline flow controller: load-use / multiply-divide stalls, multi-cycle
// mul/div busy tracking and external interrupt acceptance.
//
// Configuration macro:
//   PFC_IRQ_EDGE_EN  defined   -> irq lines are edge-captured into sticky
//                                 pending bits, cleared when taken
//                    undefined -> pending follows irq directly (level mode)
//
// Parameters: NUM_IRQ (1..32), MUL_LAT (>=2), DIV_LAT (>=2), CNT_W (busy
//             counter width, must hold max(MUL_LAT,DIV_LAT)-1)
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   irq            in   [NUM_IRQ] external interrupt lines
//   irq_mask       in   [NUM_IRQ] per-line enable (1 = enabled)
//   exl            in   exception level, blocks acceptance
//   uncertain_jump in   ID holds a branch / register jump
//   load_use       in   load-use hazard in ID
//   md_start       in   ID holds mult/multu/div/divu
//   md_is_div      in   qualifies md_start, 1 = divide
//   md_access      in   ID holds mfhi/mflo/mthi/mtlo
//   pipeline_stall out  hold IF/ID, bubble EX
//   pc_write       out  PC update enable
//   id_flush       out  bubble into ID/EX
//   if_flush       out  flush IF/ID on interrupt entry
//   int_req        out  one-cycle interrupt entry pulse
//   int_cause      out  index of last accepted line
//   md_busy        out  multiply/divide in flight
// ---------------------------------------------------------------------------
module pipe_flow_ctrl
    import pipeline_pkg::*;
#(
    parameter int NUM_IRQ = PFC_NUM_IRQ_DEF,
    parameter int MUL_LAT = PFC_MUL_LAT_DEF,
    parameter int DIV_LAT = PFC_DIV_LAT_DEF,
    parameter int CNT_W   = PFC_CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_IRQ-1:0]            irq,
    input  logic [NUM_IRQ-1:0]            irq_mask,
    input  logic                          exl,
    input  logic                          uncertain_jump,
    input  logic                          load_use,
    input  logic                          md_start,
    input  logic                          md_is_div,
    input  logic                          md_access,
    output logic                          pipeline_stall,
    output logic                          pc_write,
    output logic                          id_flush,
    output logic                          if_flush,
    output logic                          int_req,
    output logic [pfc_idx_w(NUM_IRQ)-1:0] int_cause,
    output logic                          md_busy
);

    localparam int IDX_W = pfc_idx_w(NUM_IRQ);

    // Counter reload values: the busy state lasts count+1 cycles.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    pfc_state_t         state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [IDX_W-1:0]   cause_reg, cause_next;

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] eligible;
    logic               elig_any;
    logic [IDX_W-1:0]   elig_idx;
    logic               md_go;
    logic               accept;

    // -----------------------------------------------------------------------
    // Pending interrupt source
    // -----------------------------------------------------------------------
`ifdef PFC_IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] irq_prev_reg;
    logic [NUM_IRQ-1:0] pending_reg, pending_next;
    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] clr_mask;

    assign irq_rise = irq & ~irq_prev_reg;

    // The bit being serviced is cleared during the int_req cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_clr
            assign clr_mask[gi] = int_req && (cause_reg == IDX_W'(gi));
        end
    endgenerate

    // A fresh edge wins over a clear of the same bit.
    assign pending_next = (pending_reg & ~clr_mask) | irq_rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_prev_reg <= '0;
            pending_reg  <= '0;
        end else begin
            irq_prev_reg <= irq;
            pending_reg  <= pending_next;
        end
    end

    // The edge seen this cycle is already eligible, so edge mode takes an
    // interrupt with the same one-cycle latency as level mode.
    assign pending = pending_reg | irq_rise;
`else
    assign pending = irq;
`endif

    assign eligible = pending & irq_mask;

    pfc_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .req (eligible),
        .any (elig_any),
        .idx (elig_idx)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            cause_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            cause_reg <= cause_next;
        end
    end

    // Launch/accept qualifiers. md_start has priority over an interrupt in
    // the same cycle; the interrupt simply stays eligible.
    assign md_go  = (state_reg == IDLE) && md_start && !pipeline_stall;
    assign accept = (state_reg == IDLE) && elig_any && !exl &&
                    !uncertain_jump && !load_use && !md_start;

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        cause_next = cause_reg;
        case (state_reg)
            IDLE: begin
                if (md_go) begin
                    state_next = MD_BUSY;
                    count_next = md_is_div ? DIV_CNT : MUL_CNT;
                end else if (accept) begin
                    state_next = INT_TAKE;
                    cause_next = elig_idx;
                end
            end
            MD_BUSY: begin
                if (count_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    count_next = count_reg - CNT_W'(1);
                end
            end
            INT_TAKE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        md_busy        = (state_reg == MD_BUSY);
        int_req        = (state_reg == INT_TAKE);
        if_flush       = (state_reg == INT_TAKE);
        pipeline_stall = load_use | (md_busy & (md_start | md_access));
        pc_write       = !pipeline_stall;
        id_flush       = pipeline_stall;
    end

    assign int_cause = cause_reg;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_flow_ctrl
// Directed bench for pipe_flow_ctrl (NUM_IRQ=6, MUL_LAT=5, DIV_LAT=10).
// Expected interrupt causes are queued when the stimulus is driven and popped
// when the DUT raises int_req. Expectations that differ between level mode
// and PFC_IRQ_EDGE_EN are selected with the same macro.
// ---------------------------------------------------------------------------
module tb_pipe_flow_ctrl;

    localparam int NUM_IRQ = 6;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;
    localparam int CNT_W   = 5;

`ifdef PFC_IRQ_EDGE_EN
    localparam int PULSE_K = 7;   // int_req one cycle after IDLE resumes
`else
    localparam int PULSE_K = 0;   // short pulse during busy is lost
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_IRQ-1:0] irq = '0;
    logic [NUM_IRQ-1:0] irq_mask = '1;
    logic               exl = 1'b0;
    logic               uncertain_jump = 1'b0;
    logic               load_use = 1'b0;
    logic               md_start = 1'b0;
    logic               md_is_div = 1'b0;
    logic               md_access = 1'b0;
    logic               pipeline_stall;
    logic               pc_write;
    logic               id_flush;
    logic               if_flush;
    logic               int_req;
    logic [2:0]         int_cause;
    logic               md_busy;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cause_q[$];
    int busy_cnt;

    always #5 clk = ~clk;

    pipe_flow_ctrl #(
        .NUM_IRQ (NUM_IRQ),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .irq            (irq),
        .irq_mask       (irq_mask),
        .exl            (exl),
        .uncertain_jump (uncertain_jump),
        .load_use       (load_use),
        .md_start       (md_start),
        .md_is_div      (md_is_div),
        .md_access      (md_access),
        .pipeline_stall (pipeline_stall),
        .pc_write       (pc_write),
        .id_flush       (id_flush),
        .if_flush       (if_flush),
        .int_req        (int_req),
        .int_cause      (int_cause),
        .md_busy        (md_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Interrupt entry observed: flags must be up and the cause must match the
    // oldest queued expectation.
    task automatic chk_pulse(input string tag);
        int exp_c;
        chk({tag, "_int_req"}, int_req, 1);
        chk({tag, "_if_flush"}, if_flush, 1);
        if (exp_cause_q.size() != 0) begin
            exp_c = exp_cause_q.pop_front();
            chk({tag, "_cause"}, int_cause, exp_c);
        end else begin
            n_assert++;
            n_fail++;
            $error("FAIL %s_cause: observed %0d expected no queued entry", tag, int_cause);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_no_int(input string tag);
        chk({tag, "_int_req"}, int_req, 0);
        chk({tag, "_if_flush"}, if_flush, 0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        #2 reset = 1'b0;
        #1;
        chk("rst_md_busy", md_busy, 0);
        chk_no_int("rst");
        chk("rst_cause", int_cause, 0);
        chk("rst_stall", pipeline_stall, 0);
        chk("rst_pc_write", pc_write, 1);
        chk("rst_id_flush", id_flush, 0);
        step();
        step();
        @(negedge clk) reset = 1'b1;
        step();

        // ---------------- divide: busy length and md_access stall ----------
        md_start = 1'b1;
        md_is_div = 1'b1;
        #1;
        chk("div_start_stall", pipeline_stall, 0);
        step();
        md_start = 1'b0;
        busy_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            md_access = (k >= 3);
            #1;
            if (md_busy) busy_cnt++;
            chk($sformatf("div_busy_k%0d", k), md_busy, k <= 10);
            chk($sformatf("div_stall_k%0d", k), pipeline_stall, (k >= 3) && (k <= 10));
            chk($sformatf("div_pc_write_k%0d", k), pc_write, !((k >= 3) && (k <= 10)));
            chk($sformatf("div_id_flush_k%0d", k), id_flush, (k >= 3) && (k <= 10));
            step();
        end
        md_access = 1'b0;
        chk("div_busy_cycles", busy_cnt, DIV_LAT);

        // ---------------- lowest eligible index wins ----------------
        irq = 6'b010100;
        exp_cause_q.push_back(2);
        #1;
        chk_no_int("irq_pre");
        step();
        chk_pulse("irq_lowest");
        irq = '0;
        step();
        chk_no_int("irq_after");
        chk("irq_cause_hold", int_cause, 2);
`ifdef PFC_IRQ_EDGE_EN
        // Line 4 stayed latched and is taken next.
        exp_cause_q.push_back(4);
        step();
        chk_pulse("irq_edge_second");
        step();
        chk_no_int("irq_edge_after");
`endif

        // ---------------- uncertain_jump blocks acceptance ----------------
        uncertain_jump = 1'b1;
        irq = 6'b000001;
        step();
        chk_no_int("uj_1");
        step();
        chk_no_int("uj_2");
        uncertain_jump = 1'b0;
        exp_cause_q.push_back(0);
        step();
        chk_pulse("uj_release");
        irq = '0;
        step();
        chk_no_int("uj_after");
        chk("uj_cause_hold", int_cause, 0);

        // ---------------- exl blocks acceptance ----------------
        exl = 1'b1;
        irq = 6'b001000;
        step();
        chk_no_int("exl_1");
        step();
        chk_no_int("exl_2");
        exl = 1'b0;
        exp_cause_q.push_back(3);
        step();
        chk_pulse("exl_release");
        irq = '0;
        step();

        // ---------------- md_start beats an interrupt ----------------
        irq = 6'b000010;
        md_start = 1'b1;
        md_is_div = 1'b0;
        exp_cause_q.push_back(1);
        step();
        md_start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("mul_busy_k%0d", k), md_busy, k <= MUL_LAT);
            chk($sformatf("mul_noint_k%0d", k), int_req, 0);
            step();
        end
        chk_pulse("mul_then_irq");
        irq = '0;
        step();

        // ---------------- mask gating ----------------
        irq = 6'b100000;
        irq_mask = 6'b011111;
        step();
        chk_no_int("mask_1");
        step();
        chk_no_int("mask_2");
        irq_mask = '1;
        exp_cause_q.push_back(5);
        step();
        chk_pulse("mask_open");
        irq = '0;
        step();

        // ---------------- load_use stalls and blocks ----------------
        load_use = 1'b1;
        irq = 6'b000010;
        md_start = 1'b1;
        md_is_div = 1'b1;
        #1;
        chk("lu_stall", pipeline_stall, 1);
        chk("lu_pc_write", pc_write, 0);
        chk("lu_id_flush", id_flush, 1);
        step();
        chk("lu_no_md", md_busy, 0);
        chk_no_int("lu_1");
        md_start = 1'b0;
        step();
        chk_no_int("lu_2");
        load_use = 1'b0;
        exp_cause_q.push_back(1);
        step();
        chk_pulse("lu_release");
        irq = '0;
        step();

        // ---------------- short irq[4] pulse during multiply ----------------
        md_start = 1'b1;
        md_is_div = 1'b0;
        step();
        md_start = 1'b0;
`ifdef PFC_IRQ_EDGE_EN
        exp_cause_q.push_back(4);
`endif
        for (int k = 1; k <= 9; k++) begin
            irq = (k == 2) ? 6'b010000 : 6'b000000;
            #1;
            if (k == PULSE_K) begin
                chk_pulse("pulse_during_mul");
            end else begin
                chk($sformatf("pulse_noint_k%0d", k), int_req, 0);
            end
            step();
        end
        irq = '0;

        // ---------------- reset mid-divide (counter 6) ----------------
        md_start = 1'b1;
        md_is_div = 1'b1;
        step();
        md_start = 1'b0;
        md_access = 1'b1;
        step();
        step();
        step();
        chk("rdiv_busy_before", md_busy, 1);
        chk("rdiv_stall_before", pipeline_stall, 1);
        reset = 1'b0;
        #1;
        chk("rdiv_md_busy", md_busy, 0);
        chk_no_int("rdiv");
        chk("rdiv_cause", int_cause, 0);
        chk("rdiv_stall", pipeline_stall, 0);
        chk("rdiv_pc_write", pc_write, 1);
        md_access = 1'b0;
        @(negedge clk) reset = 1'b1;
        step();
        chk("rdiv_busy_after", md_busy, 0);
        chk_no_int("rdiv_after");

        // ---------------- reset during INT_TAKE ----------------
        irq = 6'b000100;
        exp_cause_q.push_back(2);
        step();
        chk_pulse("rint_take");
        irq = '0;
        reset = 1'b0;
        #1;
        chk_no_int("rint_abort");
        chk("rint_cause", int_cause, 0);
        @(negedge clk) reset = 1'b1;
        step();
        chk_no_int("rint_after_1");
        step();
        chk_no_int("rint_after_2");

        chk("scoreboard_empty", exp_cause_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected end of sequence");
        $fatal(1, "watchdog expired");
    end

endmodule
